demux_1x4_rr_sched: RTL and testbench
=====================================

// Module: demux_1x4_rr_sched
// PURPOSE
//  Round-robin scheduler for the 1x4 demultiplexer. It accepts a valid/ready input stream and holds each beat in
//  a one-entry output buffer. It drives the demux select pair sel[1:0] (sel[1]=s1, sel[0]=s0) and routes the beat
//  to one of four valid/ready sinks. It sends BURST_LEN beats to each enabled channel, then advances to the next.
// PARAMETERS
//  DATA_W     8   width of in_data/out_data
//  BURST_LEN  4   beats sent to a channel before advancing (>=1); counter width $clog2(BURST_LEN+1)
//  TIMEOUT    16  stall cycles before a held beat is dropped (used only with DEMUX_SCHED_TIMEOUT_EN; >=1)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  chan_en    in   4       per-channel enable mask; bit i = sink i eligible
//  in_data    in   DATA_W  input beat
//  in_valid   in   1       input beat valid
//  in_ready   out  1       scheduler can take a beat this cycle
//  out_data   out  DATA_W  buffered beat, shared by all sinks (demux d)
//  out_valid  out  4       one-hot valid = full ? (1<<sel) : 0
//  out_ready  in   4       per-sink ready
//  sel        out  2       current channel, direct to demux s1/s0
//  drop       out  1       one-cycle pulse when a held beat is discarded (only with DEMUX_SCHED_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: sel=0, full=0, out_valid=0, out_data=0, beat_cnt=0, drop=0, wait_cnt=0. Reset overrides everything,
//    including mid-transfer; a held beat is lost without a drop pulse.
//  - Events:
//    - in_fire  = in_valid & in_ready
//    - out_fire = full & out_ready[sel]
//  - in_ready = |chan_en & (!full | out_fire). This is combinational from out_ready and gives 1 beat/clk
//    throughput. No path runs from in_valid to in_ready.
//  - Buffer, on in_fire: out_data<=in_data, full<=1. On out_fire without in_fire: full<=0. On both: the buffer is
//    reloaded in the same cycle and stays full.
//  - out_data holds its last value when empty. Sinks qualify it with out_valid only.
//  - On out_fire: beat_cnt++. When beat_cnt==BURST_LEN-1, the burst ends: beat_cnt<=0 and sel<=next(sel).
//  - next(sel) = first i in sel+1, sel+2, sel+3, sel (mod 4) with chan_en[i]=1, sampled in the advance cycle.
//    If only sel is enabled, sel stays.
//  - A beat loaded in the advance cycle goes out on the new sel. sel applies at drain time, not at load time.
//  - chan_en[sel]==0 while empty and |chan_en: next cycle sel<=next(sel), beat_cnt<=0.
//  - chan_en[sel]==0 while full: the beat is held on sel until accepted; sel and beat_cnt are unchanged.
//  - chan_en==0: in_ready=0 and sel is frozen. A full buffer is still drained to sel.
//  - Each beat is delivered at most once. Order is preserved within the input stream.
//  - Latency: in_fire at cycle N gives out_valid at N+1.
//  - BURST_LEN=1 gives pure per-beat round-robin.
//  - State summary:
//    - EMPTY (full=0) -> FULL on in_fire.
//    - FULL -> EMPTY on out_fire & !in_fire.
//    - FULL -> FULL on reload.
// CONFIGURATION
//  DEMUX_SCHED_TIMEOUT_EN defined:
//   - wait_cnt counts cycles with full & !out_ready[sel]. It clears on out_fire, on reload and when empty.
//   - When wait_cnt==TIMEOUT-1 and still stalled, in that cycle:
//     - full<=0 and drop=1 for one cycle
//     - sel<=next(sel), beat_cnt<=0
//     - in_ready=0 that cycle
//   - The drop port exists only in this build.
//  DEMUX_SCHED_TIMEOUT_EN undefined:
//   - No wait_cnt and no drop port. A held beat waits forever.
// TESTING
//  T1: BURST_LEN=4, chan_en=4'hF, all ready, 16 beats 0x00..0x0F -> beats 0-3 on out_valid=0001, 4-7 on 0010,
//      8-11 on 0100, 12-15 on 1000; 1 beat/clk, sel back to 0.
//  T2: chan_en=4'b1010, 8 beats -> beats 0-3 on ch1, 4-7 on ch3; ch0 and ch2 never valid.
//  T3: out_ready[sel]=0 for 5 cycles with buffer full -> out_valid/out_data stable, in_ready=0; ready=1 -> drains,
//      in_ready rises in the same cycle.
//  T4: chan_en=0 -> in_ready=0, sel frozen; chan_en=4'b0100 -> sel=2 next cycle, traffic resumes on ch2.
//  T5: rst=1 for 1 cycle while full on sel=2 with beat_cnt=2 -> next cycle: out_valid=0, sel=0, in_ready=1,
//      no drop pulse.
//  T6 (TIMEOUT_EN, TIMEOUT=16): sink 0 held not ready -> on the 16th stalled cycle drop=1 for 1 cycle, full=0,
//      sel=1; next beat goes to ch1.

Source files
------------

// File: rtl/demux_1x4_rr_sched_if.sv
// Bus bundle for demux_1x4_rr_sched: input stream, shared output data,
// one-hot per-sink valid/ready and the demux select pair.
// Optional drop pulse present only when DEMUX_SCHED_TIMEOUT_EN is defined.
interface demux_1x4_rr_sched_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]        chan_en;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [1:0]        sel;
`ifdef DEMUX_SCHED_TIMEOUT_EN
  logic              drop;

  modport master (
    output chan_en, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel, drop
  );

  modport slave (
    input  chan_en, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel, drop
  );
`else
  modport master (
    output chan_en, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel
  );

  modport slave (
    input  chan_en, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel
  );
`endif
endinterface

// File: rtl/demux_1x4_rr_sched.sv
// Round-robin scheduler for a 1x4 demux: one-entry output buffer, BURST_LEN
// beats per enabled channel, then advance to the next enabled channel.
// Optional stall timeout with drop pulse: define DEMUX_SCHED_TIMEOUT_EN.
module demux_1x4_rr_sched #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic                 clk,
  input logic                 rst,
  demux_1x4_rr_sched_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  if (BURST_LEN < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("demux_1x4_rr_sched: BURST_LEN and TIMEOUT must be >= 1");
  end

  typedef enum logic {EMPTY, FULL} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic full, out_fire, in_fire, stall, in_ready, timeout;

`ifdef DEMUX_SCHED_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  // First enabled channel after cur, wrapping back to cur; cur if none enabled.
  function automatic logic [1:0] next_sel(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] res;
    logic [1:0] cand;
    res = cur;
    // Walk from the farthest candidate down so the nearest enabled one wins.
    for (int unsigned k = 3; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (en[cand]) res = cand;
    end
    return res;
  endfunction

  assign full     = (state_q == FULL);
  assign out_fire = full & bus.out_ready[sel_q];
  assign stall    = full & ~bus.out_ready[sel_q];
`ifdef DEMUX_SCHED_TIMEOUT_EN
  assign timeout  = stall & (wait_q == WAIT_W'(TIMEOUT - 1));
`else
  assign timeout  = 1'b0;
`endif
  assign in_ready = (|bus.chan_en) & (~full | out_fire) & ~timeout;
  assign in_fire  = bus.in_valid & in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = full ? (4'b0001 << sel_q) : '0;
  assign bus.sel       = sel_q;
`ifdef DEMUX_SCHED_TIMEOUT_EN
  assign bus.drop      = timeout;
`endif

  // Next-state: buffer occupancy, burst counting and channel advance.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    if (out_fire) begin
      if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
        cnt_d = '0;
        sel_d = next_sel(sel_q, bus.chan_en);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!full && !bus.chan_en[sel_q] && (|bus.chan_en)) begin
      // Idle on a disabled channel: skip ahead so the next beat lands on a live sink.
      cnt_d = '0;
      sel_d = next_sel(sel_q, bus.chan_en);
    end else if (timeout) begin
      cnt_d = '0;
      sel_d = next_sel(sel_q, bus.chan_en);
    end

    // A load in the same cycle as a drain keeps the buffer full (reload).
    if (in_fire) begin
      data_d  = bus.in_data;
      state_d = FULL;
    end else if (out_fire || timeout) begin
      state_d = EMPTY;
    end
  end

`ifdef DEMUX_SCHED_TIMEOUT_EN
  // Stall cycle counter; any drain, reload, timeout or empty buffer clears it.
  always_comb begin
    wait_d = '0;
    if (stall && !timeout) wait_d = wait_q + WAIT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`endif

  // State registers with synchronous reset; a held beat is simply discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_demux_1x4_rr_sched.sv
// Self-checking bench for demux_1x4_rr_sched: directed scenarios plus random
// traffic, checked every cycle against a behavioural model and an order queue.
// Exercises the timeout/drop path when DEMUX_SCHED_TIMEOUT_EN is defined.
module tb_demux_1x4_rr_sched;
  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;
  localparam int unsigned TO = 16;
`ifdef DEMUX_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_1x4_rr_sched_if #(.DATA_W(DW)) bus ();

  demux_1x4_rr_sched #(
    .DATA_W   (DW),
    .BURST_LEN(BL),
    .TIMEOUT  (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: which channel is current, beats sent on it, buffer content.
  bit          m_known = 1'b0;
  int          m_sel, m_cnt, m_wait;
  bit          m_full;
  logic [7:0]  m_data;
  logic [7:0]  sb_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_next(input int s, input logic [3:0] en);
    for (int k = 1; k <= 4; k++)
      if (en[(s + k) % 4]) return (s + k) % 4;
    return s;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic r, input logic [3:0] en, input logic v,
                       input logic [7:0] d, input logic [3:0] rdy);
    bit e_stall, e_to, e_ofire, e_ir, e_ifire;
    @(negedge clk);
    rst = r; bus.chan_en = en; bus.in_valid = v; bus.in_data = d; bus.out_ready = rdy;
    #1;
    e_stall = m_full && !rdy[m_sel];
    e_to    = TO_EN && e_stall && (m_wait == TO - 1);
    e_ofire = m_full && rdy[m_sel];
    e_ir    = (en != 0) && (!m_full || e_ofire) && !e_to;
    e_ifire = v && e_ir;
    if (m_known) begin
      chk("in_ready",  bus.in_ready, e_ir);
      chk("out_valid", bus.out_valid, m_full ? (32'd1 << m_sel) : 32'd0);
      chk("out_data",  bus.out_data, m_data);
      chk("sel",       bus.sel, m_sel);
`ifdef DEMUX_SCHED_TIMEOUT_EN
      chk("drop",      bus.drop, e_to);
`endif
    end
    if (r) begin
      m_known = 1'b1;
      m_sel = 0; m_cnt = 0; m_wait = 0; m_full = 1'b0; m_data = '0;
      sb_q.delete();
      return;
    end
    if (!m_known) return;
    if (e_ofire) begin
      if (sb_q.size() == 0) chk("order_underflow", 1, 0);
      else                  chk("order", bus.out_data, sb_q.pop_front());
    end
    if (e_to && sb_q.size() != 0) void'(sb_q.pop_front());
    if (e_ofire) begin
      if (m_cnt == BL - 1) begin m_cnt = 0; m_sel = rr_next(m_sel, en); end
      else m_cnt++;
    end else if (!m_full && !en[m_sel] && en != 0) begin
      m_cnt = 0; m_sel = rr_next(m_sel, en);
    end else if (e_to) begin
      m_cnt = 0; m_sel = rr_next(m_sel, en);
    end
    if (e_ifire) begin m_data = d; m_full = 1'b1; sb_q.push_back(d); end
    else if (e_ofire || e_to) m_full = 1'b0;
    m_wait = (e_stall && !e_to) ? m_wait + 1 : 0;
  endtask

  initial begin
    logic [3:0] en_r;
    bus.chan_en = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = '0;

    cycle(1, 4'hF, 0, 8'h00, 4'hF);
    cycle(1, 4'hF, 0, 8'h00, 4'hF);

    // Burst of 16 to all channels, 1 beat per clock, then drain.
    for (int i = 0; i < 16; i++) cycle(0, 4'hF, 1, 8'(i), 4'hF);
    cycle(0, 4'hF, 0, 8'h00, 4'hF);
    @(posedge clk); #1;
    chk("t1_sel_wrap", bus.sel, 0);
    chk("t1_empty", bus.out_valid, 0);

    // Only channels 1 and 3 enabled.
    for (int i = 0; i < 8; i++) cycle(0, 4'b1010, 1, 8'(8'h40 + i), 4'hF);
    cycle(0, 4'b1010, 0, 8'h00, 4'hF);

    // Backpressure: hold the current sink not ready for 5 cycles.
    cycle(0, 4'hF, 1, 8'hA5, 4'hF);
    for (int i = 0; i < 5; i++) cycle(0, 4'hF, 1, 8'h5A, 4'h0);
    cycle(0, 4'hF, 1, 8'h5B, 4'hF);
    cycle(0, 4'hF, 0, 8'h00, 4'hF);

    // All channels disabled, then only channel 2.
    for (int i = 0; i < 3; i++) cycle(0, 4'h0, 1, 8'h77, 4'hF);
    for (int i = 0; i < 6; i++) cycle(0, 4'b0100, 1, 8'(8'h60 + i), 4'hF);
    cycle(0, 4'b0100, 0, 8'h00, 4'hF);

    // Reset while full on sel=2 with two beats already sent there.
    cycle(1, 4'hF, 0, 8'h00, 4'hF);
    for (int i = 0; i < 11; i++) cycle(0, 4'hF, 1, 8'(8'h80 + i), 4'hF);
    cycle(0, 4'hF, 0, 8'h00, 4'h0);
    @(posedge clk); #1;
    chk("t5_pre_sel", bus.sel, 2);
    chk("t5_pre_valid", bus.out_valid, 4'b0100);
    cycle(1, 4'hF, 0, 8'h00, 4'h0);
    @(posedge clk); #1;
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_sel", bus.sel, 0);
    chk("t5_in_ready", bus.in_ready, 1);
`ifdef DEMUX_SCHED_TIMEOUT_EN
    chk("t5_drop", bus.drop, 0);
`endif

`ifdef DEMUX_SCHED_TIMEOUT_EN
    // Sink 0 never ready: the held beat must be dropped and sel advance.
    cycle(0, 4'hF, 1, 8'hD0, 4'h0);
    for (int i = 0; i < TO + 2; i++) cycle(0, 4'hF, 0, 8'h00, 4'h0);
    chk("t6_sel", bus.sel, 1);
    cycle(0, 4'hF, 1, 8'hD1, 4'hF);
    cycle(0, 4'hF, 0, 8'h00, 4'hF);
`endif

    // Random traffic with occasional enable changes and resets.
    en_r = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rdy;
      if ($urandom_range(0, 19) == 0)
        en_r = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      rdy = 4'($urandom | $urandom);
      if ($urandom_range(0, 15) == 0) rdy = 4'h0;
      cycle(($urandom_range(0, 299) == 0), en_r, 1'($urandom), 8'($urandom), rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
